cu_pckt_responder: RTL and testbench

// Clocked NoC-facing front end of a compute unit (CU), i.e. the responder side of the controller packet protocol.
// - Accepts 48-bit packets {dest_id[47:43], dtype[42:40], dload[39:0]}.
// - Decodes LOADW/LOADI/MAC_CFG/MAC commands and steers the following data packets into the weight and ifmap registers.
// - Triggers the PE, then returns a SPIKERES result packet and a CMDACK packet to the controller over one output port.

---
 rtl/cu_pkg.sv | 89 ++++++++
 rtl/cu_addr_gen.sv | 50 +++++
 rtl/cu_pckt_responder.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_cu_pckt_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared constants, enums and packet/dload layouts for the CU packet responder.
package cu_pkg;

  localparam int unsigned PCKT_W     = 48;
  localparam int unsigned DLOAD_W    = 40;
  localparam int unsigned ID_W       = 5;
  localparam int unsigned DTYPE_W    = 3;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned NUMS_W     = 7;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned W_ROW_W    = 40;
  localparam int unsigned I_ROW_W    = 5;
  localparam int unsigned R_WIDTH    = 8;
  localparam int unsigned THR_W      = 8;
  localparam int unsigned OUT_ADDR_W = 8;

  localparam logic [ID_W-1:0] DEF_CU_ADDR = 5'b10000;
  localparam logic [ID_W-1:0] DEF_CTRL_ID = 5'b00000;

  typedef enum logic [DTYPE_W-1:0] {
    DT_CMD      = 3'b001,
    DT_WEIGHT   = 3'b010,
    DT_FMAP     = 3'b011,
    DT_CMDACK   = 3'b100,
    DT_SPIKERES = 3'b101
  } dtype_e;

  typedef enum logic [OP_W-1:0] {
    OP_LOADW   = 2'b00,
    OP_LOADI   = 2'b01,
    OP_MAC_CFG = 2'b10,
    OP_MAC     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FEED, S_START, S_WAIT, S_RES, S_ACK
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]    dest_id;
    logic [DTYPE_W-1:0] dtype;
    logic [DLOAD_W-1:0] dload;
  } pckt_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [NUMS_W-1:0] nums;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] stride;
    logic [20:0]       rsvd;
  } load_cmd_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             w_stat;
    logic             i_stat;
    logic [THR_W-1:0] thr;
    logic [27:0]      rsvd;
  } cfg_cmd_t;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [8:0]            rsvd;
    logic                  last;
    logic [NUMS_W-1:0]     nums;
    logic                  resin;
    logic                  resout;
    logic                  cmp;
    logic [ADDR_W-1:0]     start;
    logic [ADDR_W-1:0]     stride;
    logic [OUT_ADDR_W-1:0] out_addr;
  } mac_cmd_t;

  typedef struct packed {
    logic                  spike;
    logic [R_WIDTH-1:0]    residue;
    logic [OUT_ADDR_W-1:0] out_addr;
    logic                  last;
    logic [21:0]           rsvd;
  } res_dload_t;

  typedef struct packed {
    logic [ID_W-1:0] src_a;
    logic [ID_W-1:0] src_b;
    logic [OP_W-1:0] op;
    logic [27:0]     rsvd;
  } ack_dload_t;

endpackage

// File: rtl/cu_addr_gen.sv
// Row address walker: addr = start + k*stride (mod 32), k counts rows written.
module cu_addr_gen
  import cu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              step,
  input  logic [ADDR_W-1:0] start,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic [NUMS_W-1:0] k
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [NUMS_W-1:0] k_q, k_d;

  // Load base/stride on init, advance by stride on each written row.
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    k_d      = k_q;
    if (init) begin
      addr_d   = start;
      stride_d = stride;
      k_d      = '0;
    end else if (step) begin
      addr_d = ADDR_W'(addr_q + stride_q);
      k_d    = NUMS_W'(k_q + NUMS_W'(1));
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      k_q      <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      k_q      <= k_d;
    end
  end

  assign addr = addr_q;
  assign k    = k_q;

endmodule

// File: rtl/cu_pckt_responder.sv
// NoC-facing responder of a compute unit: decodes controller commands, steers
// data rows into weight/ifmap registers, runs the PE and returns result + ack.
module cu_pckt_responder
  import cu_pkg::*;
#(
  parameter logic [ID_W-1:0] THIS_CU_ADDR = DEF_CU_ADDR,
  parameter logic [ID_W-1:0] CTRL_ID      = DEF_CTRL_ID
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PCKT_W-1:0]     in_pckt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PCKT_W-1:0]     out_pckt,
  output logic                  w_wr_en,
  output logic [ADDR_W-1:0]     w_wr_addr,
  output logic [W_ROW_W-1:0]    w_wr_data,
  output logic                  i_wr_en,
  output logic [ADDR_W-1:0]     i_wr_addr,
  output logic [I_ROW_W-1:0]    i_wr_data,
  output logic                  cfg_ws,
  output logic                  cfg_is,
  output logic [THR_W-1:0]      cfg_thr,
  output logic                  mac_start,
  output logic [NUMS_W-1:0]     mac_nums,
  output logic [ADDR_W-1:0]     mac_reg_start,
  output logic [ADDR_W-1:0]     mac_reg_stride,
  output logic                  mac_resin,
  output logic                  mac_cmp,
  input  logic                  mac_done,
  input  logic                  mac_spike,
  input  logic [R_WIDTH-1:0]    mac_residue,
  output logic                  err_flag
);

  state_e                state_q, state_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [NUMS_W-1:0]     nums_q, nums_d;
  logic                  last_q, last_d;
  logic                  resout_q, resout_d;
  logic [OUT_ADDR_W-1:0] out_addr_q, out_addr_d;
  logic                  spike_q, spike_d;
  logic [R_WIDTH-1:0]    residue_q, residue_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [PCKT_W-1:0]     out_pckt_q, out_pckt_d;
  logic                  w_wr_en_q, w_wr_en_d;
  logic [ADDR_W-1:0]     w_wr_addr_q, w_wr_addr_d;
  logic [W_ROW_W-1:0]    w_wr_data_q, w_wr_data_d;
  logic                  i_wr_en_q, i_wr_en_d;
  logic [ADDR_W-1:0]     i_wr_addr_q, i_wr_addr_d;
  logic [I_ROW_W-1:0]    i_wr_data_q, i_wr_data_d;
  logic                  cfg_ws_q, cfg_ws_d;
  logic                  cfg_is_q, cfg_is_d;
  logic [THR_W-1:0]      cfg_thr_q, cfg_thr_d;
  logic                  mac_start_q, mac_start_d;
  logic [NUMS_W-1:0]     mac_nums_q, mac_nums_d;
  logic [ADDR_W-1:0]     mac_reg_start_q, mac_reg_start_d;
  logic [ADDR_W-1:0]     mac_reg_stride_q, mac_reg_stride_d;
  logic                  mac_resin_q, mac_resin_d;
  logic                  mac_cmp_q, mac_cmp_d;
  logic                  err_q, err_d;

  pckt_t      pkt;
  load_cmd_t  ld_cmd;
  cfg_cmd_t   cfg_cmd;
  mac_cmd_t   mac_cmd;
  res_dload_t res_dload;
  ack_dload_t ack_dload;

  logic              take;
  logic              out_hs;
  logic              row_last;
  logic              ag_init, ag_step;
  logic [ADDR_W-1:0] ag_start, ag_stride, ag_addr;
  logic [NUMS_W-1:0] ag_k;
  logic              unused_bits;

  assign pkt     = pckt_t'(in_pckt);
  assign ld_cmd  = load_cmd_t'(pkt.dload);
  assign cfg_cmd = cfg_cmd_t'(pkt.dload);
  assign mac_cmd = mac_cmd_t'(pkt.dload);

  // Foreign packets are consumed by the handshake but never reach the FSM.
  assign take     = in_valid && in_ready_q && (pkt.dest_id == THIS_CU_ADDR);
  assign out_hs   = out_valid_q && out_ready;
  assign row_last = (ag_k == NUMS_W'(nums_q - NUMS_W'(1)));

  assign unused_bits = ^{ld_cmd.rsvd, cfg_cmd.op, cfg_cmd.rsvd, mac_cmd.op, mac_cmd.rsvd};

  cu_addr_gen u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (ag_init),
    .step   (ag_step),
    .start  (ag_start),
    .stride (ag_stride),
    .addr   (ag_addr),
    .k      (ag_k)
  );

  // Next-state, command decode, register-port writes and output packet build.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    nums_d           = nums_q;
    last_d           = last_q;
    resout_d         = resout_q;
    out_addr_d       = out_addr_q;
    spike_d          = spike_q;
    residue_d        = residue_q;
    out_pckt_d       = out_pckt_q;
    w_wr_en_d        = 1'b0;
    w_wr_addr_d      = w_wr_addr_q;
    w_wr_data_d      = w_wr_data_q;
    i_wr_en_d        = 1'b0;
    i_wr_addr_d      = i_wr_addr_q;
    i_wr_data_d      = i_wr_data_q;
    cfg_ws_d         = cfg_ws_q;
    cfg_is_d         = cfg_is_q;
    cfg_thr_d        = cfg_thr_q;
    mac_nums_d       = mac_nums_q;
    mac_reg_start_d  = mac_reg_start_q;
    mac_reg_stride_d = mac_reg_stride_q;
    mac_resin_d      = mac_resin_q;
    mac_cmp_d        = mac_cmp_q;
    err_d            = err_q;
    ag_init          = 1'b0;
    ag_step          = 1'b0;
    ag_start         = ld_cmd.start;
    ag_stride        = ld_cmd.stride;
    res_dload        = '{spike: spike_q, residue: residue_q, out_addr: out_addr_q,
                         last: last_q, rsvd: '0};
    ack_dload        = '{src_a: THIS_CU_ADDR, src_b: THIS_CU_ADDR, op: op_q, rsvd: '0};

    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          if (pkt.dtype == DT_CMD) begin
            op_d = ld_cmd.op;
            unique case (ld_cmd.op)
              OP_LOADW, OP_LOADI: begin
                nums_d  = ld_cmd.nums;
                ag_init = 1'b1;
                state_d = (ld_cmd.nums == '0) ? S_ACK : S_LOAD;
              end
              OP_MAC_CFG: begin
                cfg_ws_d  = cfg_cmd.w_stat;
                cfg_is_d  = cfg_cmd.i_stat;
                cfg_thr_d = cfg_cmd.thr;
                state_d   = S_ACK;
              end
              default: begin
                nums_d           = mac_cmd.nums;
                last_d           = mac_cmd.last;
                resout_d         = mac_cmd.resout;
                out_addr_d       = mac_cmd.out_addr;
                mac_nums_d       = mac_cmd.nums;
                mac_reg_start_d  = mac_cmd.start;
                mac_reg_stride_d = mac_cmd.stride;
                mac_resin_d      = mac_cmd.resin;
                mac_cmp_d        = mac_cmd.cmp;
                ag_init          = 1'b1;
                ag_start         = mac_cmd.start;
                ag_stride        = mac_cmd.stride;
                state_d          = (mac_cmd.nums == '0) ? S_START : S_FEED;
              end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (take) begin
          if (op_q == OP_LOADW && pkt.dtype == DT_WEIGHT) begin
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = ag_addr;
            w_wr_data_d = pkt.dload[W_ROW_W-1:0];
            ag_step     = 1'b1;
            if (row_last) state_d = S_ACK;
          end else if (op_q == OP_LOADI && pkt.dtype == DT_FMAP) begin
            i_wr_en_d   = 1'b1;
            i_wr_addr_d = ag_addr;
            i_wr_data_d = pkt.dload[I_ROW_W-1:0];
            ag_step     = 1'b1;
            if (row_last) state_d = S_ACK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (take) begin
          if (pkt.dtype == DT_FMAP) begin
            i_wr_en_d   = 1'b1;
            i_wr_addr_d = ag_addr;
            i_wr_data_d = pkt.dload[I_ROW_W-1:0];
            ag_step     = 1'b1;
            if (row_last) state_d = S_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (mac_done) begin
          spike_d   = mac_spike;
          residue_d = mac_residue;
          state_d   = resout_q ? S_RES : S_ACK;
        end
      end
      S_RES: if (out_hs) state_d = S_ACK;
      S_ACK: if (out_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Valid drops for a cycle after each handshake so the next packet loads cleanly.
    out_valid_d = ((state_q == S_RES) || (state_q == S_ACK)) && !out_hs;
    if (!out_valid_q) begin
      out_pckt_d = (state_q == S_RES) ? {CTRL_ID, DT_SPIKERES, res_dload}
                                      : {CTRL_ID, DT_CMDACK, ack_dload};
    end

    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_FEED);
    mac_start_d = (state_d == S_START);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      op_q             <= '0;
      nums_q           <= '0;
      last_q           <= 1'b0;
      resout_q         <= 1'b0;
      out_addr_q       <= '0;
      spike_q          <= 1'b0;
      residue_q        <= '0;
      in_ready_q       <= 1'b0;
      out_valid_q      <= 1'b0;
      out_pckt_q       <= '0;
      w_wr_en_q        <= 1'b0;
      w_wr_addr_q      <= '0;
      w_wr_data_q      <= '0;
      i_wr_en_q        <= 1'b0;
      i_wr_addr_q      <= '0;
      i_wr_data_q      <= '0;
      cfg_ws_q         <= 1'b0;
      cfg_is_q         <= 1'b0;
      cfg_thr_q        <= '0;
      mac_start_q      <= 1'b0;
      mac_nums_q       <= '0;
      mac_reg_start_q  <= '0;
      mac_reg_stride_q <= '0;
      mac_resin_q      <= 1'b0;
      mac_cmp_q        <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      nums_q           <= nums_d;
      last_q           <= last_d;
      resout_q         <= resout_d;
      out_addr_q       <= out_addr_d;
      spike_q          <= spike_d;
      residue_q        <= residue_d;
      in_ready_q       <= in_ready_d;
      out_valid_q      <= out_valid_d;
      out_pckt_q       <= out_pckt_d;
      w_wr_en_q        <= w_wr_en_d;
      w_wr_addr_q      <= w_wr_addr_d;
      w_wr_data_q      <= w_wr_data_d;
      i_wr_en_q        <= i_wr_en_d;
      i_wr_addr_q      <= i_wr_addr_d;
      i_wr_data_q      <= i_wr_data_d;
      cfg_ws_q         <= cfg_ws_d;
      cfg_is_q         <= cfg_is_d;
      cfg_thr_q        <= cfg_thr_d;
      mac_start_q      <= mac_start_d;
      mac_nums_q       <= mac_nums_d;
      mac_reg_start_q  <= mac_reg_start_d;
      mac_reg_stride_q <= mac_reg_stride_d;
      mac_resin_q      <= mac_resin_d;
      mac_cmp_q        <= mac_cmp_d;
      err_q            <= err_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_pckt       = out_pckt_q;
  assign w_wr_en        = w_wr_en_q;
  assign w_wr_addr      = w_wr_addr_q;
  assign w_wr_data      = w_wr_data_q;
  assign i_wr_en        = i_wr_en_q;
  assign i_wr_addr      = i_wr_addr_q;
  assign i_wr_data      = i_wr_data_q;
  assign cfg_ws         = cfg_ws_q;
  assign cfg_is         = cfg_is_q;
  assign cfg_thr        = cfg_thr_q;
  assign mac_start      = mac_start_q;
  assign mac_nums       = mac_nums_q;
  assign mac_reg_start  = mac_reg_start_q;
  assign mac_reg_stride = mac_reg_stride_q;
  assign mac_resin      = mac_resin_q;
  assign mac_cmp        = mac_cmp_q;
  assign err_flag       = err_q;

endmodule

// File: tb/tb_cu_pckt_responder.sv
// Bench for cu_pckt_responder: table of load transactions plus hand-written
// MAC, stall, reset and error sequences, checked through a scoreboard.
module tb_cu_pckt_responder;
  import cu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_pckt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_pckt;
  logic        w_wr_en;
  logic [4:0]  w_wr_addr;
  logic [39:0] w_wr_data;
  logic        i_wr_en;
  logic [4:0]  i_wr_addr;
  logic [4:0]  i_wr_data;
  logic        cfg_ws, cfg_is;
  logic [7:0]  cfg_thr;
  logic        mac_start;
  logic [6:0]  mac_nums;
  logic [4:0]  mac_reg_start, mac_reg_stride;
  logic        mac_resin, mac_cmp;
  logic        mac_done = 1'b0;
  logic        mac_spike = 1'b0;
  logic [7:0]  mac_residue = '0;
  logic        err_flag;

  always #5 clk = ~clk;

  cu_pckt_responder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pckt(in_pckt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pckt(out_pckt),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .cfg_ws(cfg_ws), .cfg_is(cfg_is), .cfg_thr(cfg_thr),
    .mac_start(mac_start), .mac_nums(mac_nums),
    .mac_reg_start(mac_reg_start), .mac_reg_stride(mac_reg_stride),
    .mac_resin(mac_resin), .mac_cmp(mac_cmp),
    .mac_done(mac_done), .mac_spike(mac_spike), .mac_residue(mac_residue),
    .err_flag(err_flag)
  );

  localparam logic [4:0] ME = 5'b10000;

  typedef struct packed {
    logic        is_w;
    logic [4:0]  addr;
    logic [39:0] data;
  } wr_t;

  typedef struct {
    bit          is_w;
    int          nums;
    int          start;
    int          stride;
    logic [47:0] ack;
  } lvec_t;

  wr_t         exp_wr[$];
  logic [47:0] exp_out[$];
  int          n_checks = 0;
  int          n_errs = 0;
  int          n_start = 0;
  wr_t         mon_e;
  logic [47:0] held_pckt;
  bit          held_vld = 0;
  lvec_t       tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [47:0] mk(input logic [2:0] dt, input logic [39:0] dl);
    return {ME, dt, dl};
  endfunction

  // Scoreboard monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld <= 0;
    end else begin
      if (mac_start) n_start++;
      if (w_wr_en || i_wr_en) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          mon_e = exp_wr.pop_front();
          chk("wr_port_w", 64'(w_wr_en), 64'(mon_e.is_w));
          chk("wr_addr", 64'(w_wr_en ? w_wr_addr : i_wr_addr), 64'(mon_e.addr));
          chk("wr_data", w_wr_en ? 64'(w_wr_data) : 64'(i_wr_data), 64'(mon_e.data));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) fail_now("unexpected_out_pckt");
        else chk("out_pckt", 64'(out_pckt), 64'(exp_out.pop_front()));
        held_vld <= 0;
      end else if (out_valid) begin
        if (held_vld) chk("out_pckt_stable", 64'(out_pckt), 64'(held_pckt));
        held_pckt <= out_pckt;
        held_vld  <= 1;
      end else begin
        held_vld <= 0;
      end
    end
  end

  task automatic send(input logic [47:0] p);
    int n = 0;
    @(negedge clk);
    in_pckt  = p;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("in_ready_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_out.size() != 0 || exp_wr.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      fail_now("drain_timeout");
      exp_out.delete();
      exp_wr.delete();
    end
    @(negedge clk);
  endtask

  task automatic push_row(input bit is_w, input int start, input int stride, input int k,
                          output logic [39:0] d);
    wr_t e;
    d      = 40'({$urandom(), $urandom()});
    e.is_w = is_w;
    e.addr = 5'((start + k * stride) % 32);
    e.data = is_w ? d : {35'b0, d[4:0]};
    exp_wr.push_back(e);
  endtask

  task automatic do_load(input bit is_w, input int nums, input int start, input int stride,
                         input logic [47:0] ack);
    logic [39:0] d;
    exp_out.push_back(ack);
    send(mk(DT_CMD, {is_w ? 2'b00 : 2'b01, 7'(nums), 5'(start), 5'(stride), 21'b0}));
    for (int k = 0; k < nums; k++) begin
      push_row(is_w, start, stride, k, d);
      send(mk(is_w ? DT_WEIGHT : DT_FMAP, d));
    end
    drain();
  endtask

  task automatic do_mac(input int nums, input int start, input int stride, input bit resin,
                        input bit resout, input bit cmp, input bit last, input logic [7:0] oaddr,
                        input bit spike, input logic [7:0] residue, input bit stall);
    logic [39:0] d;
    logic [47:0] res;
    int s0, n;
    res = {5'b00000, 3'b101, spike, residue, oaddr, last, 22'b0};
    if (resout) exp_out.push_back(res);
    exp_out.push_back(48'h048430000000);
    s0 = n_start;
    send(mk(DT_CMD, {2'b11, 9'b0, last, 7'(nums), resin, resout, cmp, 5'(start), 5'(stride), oaddr}));
    for (int k = 0; k < nums; k++) begin
      push_row(1'b0, start, stride, k, d);
      send(mk(DT_FMAP, d));
    end
    n = 0;
    while (!mac_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mac_start) begin
      fail_now("mac_start_timeout");
      return;
    end
    chk("mac_nums", 64'(mac_nums), 64'(nums));
    chk("mac_reg_start", 64'(mac_reg_start), 64'(start));
    chk("mac_reg_stride", 64'(mac_reg_stride), 64'(stride));
    chk("mac_resin", 64'(mac_resin), 64'(resin));
    chk("mac_cmp", 64'(mac_cmp), 64'(cmp));
    if (stall) out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mac_done = 1'b1; mac_spike = spike; mac_residue = residue;
    @(negedge clk);
    mac_done = 1'b0; mac_spike = 1'b0; mac_residue = '0;
    if (stall) begin
      repeat (10) @(negedge clk);
      chk("res_valid_in_stall", 64'(out_valid), 64'd1);
      chk("res_pckt_in_stall", 64'(out_pckt), 64'(res));
      out_ready = 1'b1;
    end
    drain();
    chk("mac_start_count", 64'(n_start - s0), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] d;
    int n;
    tbl[0] = '{1'b1, 5, 0, 1, 48'h048400000000};
    tbl[1] = '{1'b1, 4, 30, 1, 48'h048400000000};
    tbl[2] = '{1'b0, 3, 5, 7, 48'h048410000000};
    tbl[3] = '{1'b1, 0, 3, 2, 48'h048400000000};
    tbl[4] = '{1'b0, 2, 31, 31, 48'h048410000000};

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pckt", 64'(out_pckt), 64'd0);
    chk("rst_wr_en", 64'({w_wr_en, i_wr_en, mac_start}), 64'd0);
    chk("rst_cfg", 64'({cfg_ws, cfg_is, cfg_thr}), 64'd0);
    chk("rst_err", 64'(err_flag), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Table-driven weight/ifmap loads.
    for (int i = 0; i < 5; i++)
      do_load(tbl[i].is_w, tbl[i].nums, tbl[i].start, tbl[i].stride, tbl[i].ack);

    // MAC_CFG updates and holds.
    exp_out.push_back(48'h048420000000);
    send(mk(DT_CMD, {2'b10, 1'b1, 1'b0, 8'd32, 28'b0}));
    drain();
    chk("cfg_ws", 64'(cfg_ws), 64'd1);
    chk("cfg_is", 64'(cfg_is), 64'd0);
    chk("cfg_thr", 64'(cfg_thr), 64'h20);
    exp_out.push_back(48'h048420000000);
    send(mk(DT_CMD, {2'b10, 1'b0, 1'b1, 8'hA5, 28'b0}));
    drain();
    chk("cfg2", 64'({cfg_ws, cfg_is, cfg_thr}), 64'({1'b0, 1'b1, 8'hA5}));

    // MAC with result packet, stalled result, and a zero-row MAC without result.
    do_mac(5, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'd7, 1'b0);
    do_mac(3, 29, 2, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 8'h9E, 1'b1);
    do_mac(0, 4, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 8'h01, 1'b0);
    chk("cfg_held", 64'({cfg_ws, cfg_is, cfg_thr}), 64'({1'b0, 1'b1, 8'hA5}));

    // A stray mac_done in IDLE must not produce output.
    @(negedge clk);
    mac_done = 1'b1; mac_spike = 1'b1;
    @(negedge clk);
    mac_done = 1'b0; mac_spike = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_done_no_out", 64'(out_valid), 64'd0);

    // Reset during a partial load loses it; next load starts afresh.
    send(mk(DT_CMD, {2'b00, 7'd4, 5'd10, 5'd3, 21'b0}));
    for (int k = 0; k < 2; k++) begin
      push_row(1'b1, 10, 3, k, d);
      send(mk(DT_WEIGHT, d));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_wr_pending", 64'(exp_wr.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(1'b1, 2, 7, 1, 48'h048400000000);

    // Reset while an ack is held drops out_valid at once.
    out_ready = 1'b0;
    send(mk(DT_CMD, {2'b01, 7'd1, 5'd2, 5'd1, 21'b0}));
    push_row(1'b0, 2, 1, 0, d);
    send(mk(DT_FMAP, d));
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack_held_valid", 64'(out_valid), 64'd1);
    chk("ack_held_pckt", 64'(out_pckt), 64'h048410000000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drops_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Foreign packet dropped silently; data packet in IDLE flags an error.
    send({5'b00011, DT_WEIGHT, 40'hFF_FFFF_FFFF});
    repeat (2) @(negedge clk);
    chk("foreign_no_err", 64'(err_flag), 64'd0);
    send(mk(DT_FMAP, 40'h1F));
    repeat (2) @(negedge clk);
    chk("fmap_idle_err", 64'(err_flag), 64'd1);

    // Wrong dtype inside a load is dropped; the load still completes.
    exp_out.push_back(48'h048400000000);
    send(mk(DT_CMD, {2'b00, 7'd1, 5'd9, 5'd4, 21'b0}));
    send(mk(DT_FMAP, 40'h3));
    push_row(1'b1, 9, 4, 0, d);
    send(mk(DT_WEIGHT, d));
    drain();
    chk("err_sticky", 64'(err_flag), 64'd1);

    chk("scoreboard_empty", 64'(exp_out.size() + exp_wr.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
